// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: bundles the fetch controller's instruction-memory bus,
// decode handshake, redirect input and status outputs.
//   master : fetch controller side (drives imem_addr, inst_*, status)
//   slave  : environment side (memory, decode, branch unit)
// Signals:
//   imem_addr      byte address to instruction memory (the PC)
//   imem_data      combinational read data for imem_addr
//   inst_valid     FIFO head holds a valid instruction
//   inst_ready     decode accepts the head this cycle
//   inst_data      head instruction word
//   inst_pc        PC of the head instruction
//   redirect_valid load a new PC and flush the FIFO
//   redirect_pc    redirect target PC
//   fetch_halted   PC out of range, fetching stopped
//   fault          sticky misaligned-redirect flag
interface imem_fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_halted;
   logic        fault;

   modport master (
      output imem_addr,
      input  imem_data,
      output inst_valid,
      input  inst_ready,
      output inst_data,
      output inst_pc,
      input  redirect_valid,
      input  redirect_pc,
      output fetch_halted,
      output fault
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  inst_valid,
      output inst_ready,
      input  inst_data,
      input  inst_pc,
      output redirect_valid,
      output redirect_pc,
      input  fetch_halted,
      input  fault
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer. Owns the PC, reads one word per
// cycle from a combinational instruction memory, queues {pc, word} in a small
// prefetch FIFO and hands entries to decode over valid/ready. A redirect
// flushes the FIFO and reloads the PC.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    imem_fetch_ctrl_if.master (memory bus, decode handshake,
//          redirect, fetch_halted, fault)
// Optional feature macro: IMEM_ALIGN_CHECK_EN
//   defined   : a misaligned redirect enters a sticky FAULT state
//   undefined : redirect_pc[1:0] is cleared, fault is tied 0
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MEM_BYTES  = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   imem_fetch_ctrl_if.master       bus
);

   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned PW      = AW + 1;
   localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_FULL  = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [PW-1:0] w_rd_ptr_nxt;
   entry_t        r_fifo [FIFO_DEPTH];
   entry_t        w_head;

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_redir;
   logic          w_misalign;
   logic [31:0]   w_redir_pc;

   // Pointer-based occupancy: equal pointers = empty, MSB differs = full
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A FAULTed fetcher ignores redirects; only reset clears it
   assign w_redir = bus.redirect_valid && (r_state != ST_FAULT);
   assign w_pop   = !w_empty && bus.inst_ready;

`ifdef IMEM_ALIGN_CHECK_EN
   assign w_misalign = w_redir && (bus.redirect_pc[1:0] != 2'b00);
   assign w_redir_pc = bus.redirect_pc;
`else
   assign w_misalign = 1'b0;
   assign w_redir_pc = bus.redirect_pc & ~32'h0000_0003;
`endif

   // Capture this cycle's word when in range, not redirected, and a slot frees up
   assign w_push = !w_redir &&
                   ((r_state == ST_FETCH) || (r_state == ST_FULL)) &&
                   (r_pc <= LAST_PC) &&
                   (!w_full || w_pop);

   // Next-state, next-PC and pointer update
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;

      if (r_state == ST_FAULT) begin
         w_state_nxt = ST_FAULT;
      end else if (w_redir) begin
         // Flush; a head transfer in this cycle is still consumed by decode
         w_pc_nxt     = w_redir_pc;
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         if (w_misalign) begin
            w_state_nxt = ST_FAULT;
         end else if (w_redir_pc > LAST_PC) begin
            w_state_nxt = ST_HALT;
         end else begin
            w_state_nxt = ST_FETCH;
         end
      end else begin
         if (w_push) begin
            w_pc_nxt     = r_pc + 32'd4;
            w_wr_ptr_nxt = r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PW'(1);
         end
         if (w_pc_nxt > LAST_PC) begin
            w_state_nxt = ST_HALT;
         end else if ((w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]) &&
                      (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                      !w_pop) begin
            w_state_nxt = ST_FULL;
         end else begin
            w_state_nxt = ST_FETCH;
         end
      end
   end

   // State, PC and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_PC;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
      end
   end

   // FIFO storage; contents are never observed while empty, so no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr[AW-1:0]] <= {r_pc, bus.imem_data};
      end
   end

   assign w_head = r_fifo[r_rd_ptr[AW-1:0]];

   assign bus.imem_addr    = r_pc;
   assign bus.inst_valid   = !w_empty;
   assign bus.inst_data    = w_empty ? 32'h0 : w_head.data;
   assign bus.inst_pc      = w_empty ? 32'h0 : w_head.pc;
   assign bus.fetch_halted = (r_state == ST_HALT);
`ifdef IMEM_ALIGN_CHECK_EN
   assign bus.fault        = (r_state == ST_FAULT);
`else
   assign bus.fault        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a negedge monitor pops the expected PC stream
// from a scoreboard queue on every decode transfer; scenario tasks add
// inline timing and status checks.
module tb_imem_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] LAST_PC  = 32'h0000_03FC;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [31:0] exp_q[$];
   logic [31:0] last_pc;

   imem_fetch_ctrl_if bus ();

   imem_fetch_ctrl #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(2),
      .MEM_BYTES (1024)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h2008_0005;
         32'h4:   return 32'h2009_0003;
         default: return 32'h8C00_0000 ^ (a * 32'h0001_0001);
      endcase
   endfunction

   assign bus.imem_data = mem_word(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every accepted head must be the next expected PC
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && bus.inst_valid && bus.inst_ready) begin
         total++;
         last_pc = bus.inst_pc;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got pc=%h data=%h, expected no transfer", bus.inst_pc, bus.inst_data);
         end else begin
            e = exp_q.pop_front();
            if (bus.inst_pc !== e || bus.inst_data !== mem_word(e)) begin
               bad++;
               $display("FAIL sb_order: got pc=%h data=%h, expected pc=%h data=%h",
                        bus.inst_pc, bus.inst_data, e, mem_word(e));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_stream(input logic [31:0] t);
      exp_q.delete();
      for (logic [31:0] p = t; p <= LAST_PC; p += 32'd4) exp_q.push_back(p);
   endtask

   task automatic do_reset(input logic rdy);
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.inst_ready = rdy;
      start_stream(RESET_PC);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic do_redirect(input logic [31:0] t, input logic rdy);
      @(posedge clk); #1;
      bus.inst_ready = rdy;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = t;
      @(posedge clk); #1;
      bus.redirect_valid = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
      if (t[1:0] != 2'b00) exp_q.delete();
      else start_stream(t);
`else
      start_stream(t & ~32'h3);
`endif
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      start_stream(RESET_PC);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b exp 0", bus.inst_valid); end
      total++; if (bus.inst_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h exp 0", bus.inst_data); end
      total++; if (bus.inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h exp 0", bus.inst_pc); end
      total++; if (bus.imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr: got %h exp %h", bus.imem_addr, RESET_PC); end
      total++; if (bus.fetch_halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b exp 0", bus.fetch_halted); end
      total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b exp 0", bus.fault); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.inst_valid !== 1'b0) begin bad++; $display("FAIL lat_c0: got valid %b exp 0", bus.inst_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin
            bad++; $display("FAIL lat_seq%0d: got valid=%b pc=%h exp 1/%h", i, bus.inst_valid, bus.inst_pc, 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      repeat (5) @(negedge clk);
      total++; if (bus.imem_addr !== 32'h8) begin bad++; $display("FAIL bp_addr: got %h exp 8", bus.imem_addr); end
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
         bad++; $display("FAIL bp_head: got valid=%b pc=%h exp 1/0", bus.inst_valid, bus.inst_pc); end
      @(posedge clk); #1;
      bus.inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin
            bad++; $display("FAIL bp_drain%0d: got valid=%b pc=%h exp 1/%h", i, bus.inst_valid, bus.inst_pc, 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect();
      bit seen;
      do_reset(1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.inst_valid && bus.inst_pc == 32'h4) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL rd_wait: head pc 4 not seen, got %h", bus.inst_pc); end
      @(posedge clk); #1;
      bus.inst_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (bus.inst_pc !== 32'h8 || bus.imem_addr !== 32'h10) begin
         bad++; $display("FAIL rd_pre: got pc=%h addr=%h exp 8/10", bus.inst_pc, bus.imem_addr); end
      do_redirect(32'h40, 1'b1);
      @(negedge clk);
      total++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
         bad++; $display("FAIL rd_flush: got valid=%b addr=%h exp 0/40", bus.inst_valid, bus.imem_addr); end
      @(negedge clk);
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin
         bad++; $display("FAIL rd_first: got valid=%b pc=%h exp 1/40", bus.inst_valid, bus.inst_pc); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_halt();
      bit halted;
      do_reset(1'b1);
      halted = 1'b0;
      for (int i = 0; i < 400 && !halted; i++) begin
         @(negedge clk);
         if (bus.fetch_halted) halted = 1'b1;
      end
      total++; if (!halted) begin bad++; $display("FAIL halt_wait: fetch_halted never rose"); end
      repeat (4) @(negedge clk);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_left: %0d expected entries undelivered", exp_q.size()); end
      total++; if (last_pc !== LAST_PC) begin bad++; $display("FAIL halt_last: got %h exp %h", last_pc, LAST_PC); end
      total++; if (bus.fetch_halted !== 1'b1 || bus.imem_addr !== 32'h400 || bus.inst_valid !== 1'b0) begin
         bad++; $display("FAIL halt_hold: got halted=%b addr=%h valid=%b exp 1/400/0",
                         bus.fetch_halted, bus.imem_addr, bus.inst_valid); end
      do_redirect(32'h10, 1'b1);
      @(negedge clk);
      total++; if (bus.fetch_halted !== 1'b0 || bus.imem_addr !== 32'h10) begin
         bad++; $display("FAIL halt_resume: got halted=%b addr=%h exp 0/10", bus.fetch_halted, bus.imem_addr); end
      @(negedge clk);
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10) begin
         bad++; $display("FAIL halt_first: got valid=%b pc=%h exp 1/10", bus.inst_valid, bus.inst_pc); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_async_reset();
      do_reset(1'b0);
      repeat (4) @(negedge clk);
      total++; if (bus.inst_valid !== 1'b1 || bus.imem_addr !== 32'h8) begin
         bad++; $display("FAIL ar_full: got valid=%b addr=%h exp 1/8", bus.inst_valid, bus.imem_addr); end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      total++; if (bus.inst_valid !== 1'b0 || bus.imem_addr !== RESET_PC || bus.inst_pc !== 32'h0) begin
         bad++; $display("FAIL ar_clear: got valid=%b addr=%h pc=%h exp 0/%h/0",
                         bus.inst_valid, bus.imem_addr, bus.inst_pc, RESET_PC); end
      start_stream(RESET_PC);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.inst_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_misaligned();
      do_redirect(32'h42, 1'b1);
`ifdef IMEM_ALIGN_CHECK_EN
      total++; if (bus.imem_addr !== 32'h42) begin bad++; $display("FAIL mis_addr: got %h exp 42", bus.imem_addr); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin
            bad++; $display("FAIL mis_fault%0d: got fault=%b valid=%b exp 1/0", i, bus.fault, bus.inst_valid);
         end
      end
      do_reset(1'b1);
      @(negedge clk);
      total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL mis_clear: got fault=%b exp 0", bus.fault); end
`else
      @(negedge clk);
      total++; if (bus.imem_addr !== 32'h40 || bus.fault !== 1'b0) begin
         bad++; $display("FAIL mis_addr: got addr=%h fault=%b exp 40/0", bus.imem_addr, bus.fault); end
      @(negedge clk);
      total++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin
         bad++; $display("FAIL mis_first: got valid=%b pc=%h exp 1/40", bus.inst_valid, bus.inst_pc); end
`endif
      repeat (3) @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad = 0;
      last_pc = 32'h0;
      test_reset();
      test_backpressure();
      test_redirect();
      test_halt();
      test_async_reset();
      test_misaligned();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
